// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RV32I 5-stage hazard controller: load-use stall, branch flush, forwarding, dmem freeze
// All state advances on negedge clk together with the pipeline registers; control outputs are combinational.
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_id,
  input  logic [31:0]      inst_ex,
  input  logic [31:0]      inst_mem,
  input  logic [31:0]      inst_wb,
  input  logic             branch_taken,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              stall_evt, flush_evt;

  function automatic logic writes_rd(input logic [11:0] lo);
    logic op_ok;
    case (lo[6:0])
      OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
    return op_ok && (lo[11:7] != 5'd0);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_R, OP_STORE, OP_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs);
    if (!used)                                                 return 2'b00;
    else if (writes_rd(inst_mem[11:0]) && inst_mem[11:7] == rs) return 2'b10;
    else if (writes_rd(inst_wb[11:0]) && inst_wb[11:7] == rs)   return 2'b01;
    else                                                       return 2'b00;
  endfunction

  logic unused_bits;
  assign unused_bits = ^{inst_id[31:25], inst_id[14:0], inst_ex[31:25], inst_ex[14:12],
                         inst_mem[31:12], inst_wb[31:12]};

  logic [4:0] ex_rd;
  logic       load_use, mem_access;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign ex_rd      = inst_ex[11:7];
  assign load_use   = (inst_ex[6:0] == OP_LOAD) && (ex_rd != 5'd0) &&
                      ((uses_rs1(inst_id[6:0]) && inst_id[19:15] == ex_rd) ||
                       (uses_rs2(inst_id[6:0]) && inst_id[24:20] == ex_rd));
  assign mem_access = (inst_mem[6:0] == OP_LOAD) || (inst_mem[6:0] == OP_STORE);
  assign fwd_a_raw  = fwd_sel(uses_rs1(inst_ex[6:0]), inst_ex[19:15]);
  assign fwd_b_raw  = fwd_sel(uses_rs2(inst_ex[6:0]), inst_ex[24:20]);
  assign mem_err    = (state == ERROR);

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    dmem_req   = 1'b0;
    next_state = state;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    if (!rst) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      if (state == ERROR) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
      end else begin
        dmem_req = mem_access || (state == MEM_WAIT);
        if (dmem_req && !dmem_ready) begin
          // Freeze overrides any branch or load-use; they are re-evaluated once released.
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
          stall_evt = 1'b1;
          if (state == RUN)                next_state = MEM_WAIT;
          else if (wait_cnt == WAIT_LAST)  next_state = ERROR;
        end else begin
          if (state == MEM_WAIT) next_state = RUN;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_evt  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == RUN && next_state == MEM_WAIT)
        wait_cnt <= '0;
      else if (state == MEM_WAIT && next_state == MEM_WAIT)
        wait_cnt <= wait_cnt + 1'b1;
      if (stall_evt && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - table-driven scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 2;
  localparam int MEM_TIMEOUT = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] inst_id, inst_ex, inst_mem, inst_wb;
  logic branch_taken, dmem_ready;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic dmem_req, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .inst_id(inst_id), .inst_ex(inst_ex), .inst_mem(inst_mem), .inst_wb(inst_wb),
    .branch_taken(branch_taken), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .dmem_req(dmem_req), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] id, ex, mem, wb;
    logic        br, rdy;
    logic [4:0]  en;
    logic [1:0]  fl, fa, fb;
    logic        req;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[15];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_op(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, op};
  endfunction
  function automatic logic [31:0] s_sw(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] b_beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
    return i_op(7'b0000011, rd, rs1, 12'd0);
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1);
    return i_op(7'b0010011, rd, rs1, 12'd1);
  endfunction

  function automatic vec_t mk(input logic [31:0] id, input logic [31:0] ex, input logic [31:0] mem,
                              input logic [31:0] wb, input logic br, input logic rdy, input logic [4:0] en,
                              input logic [1:0] fl, input logic [1:0] fa, input logic [1:0] fb,
                              input logic req);
    vec_t v;
    v.id = id; v.ex = ex; v.mem = mem; v.wb = wb; v.br = br; v.rdy = rdy;
    v.en = en; v.fl = fl; v.fa = fa; v.fb = fb; v.req = req;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    #1;
    inst_id = v.id; inst_ex = v.ex; inst_mem = v.mem; inst_wb = v.wb;
    branch_taken = v.br; dmem_ready = v.rdy;
    sb.push_back(v);
  endtask

  task automatic sample(input string tag);
    vec_t e;
    @(posedge clk);
    e = sb.pop_front();
    chk({tag, "_en"}, {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, e.en});
    chk({tag, "_flush"}, {30'd0, ifid_flush, idex_flush}, {30'd0, e.fl});
    chk({tag, "_fwd"}, {28'd0, fwd_a, fwd_b}, {28'd0, e.fa, e.fb});
    chk({tag, "_req"}, {31'd0, dmem_req}, {31'd0, e.req});
  endtask

  task automatic step(input vec_t v, input string tag);
    drive(v);
    sample(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    inst_id = NOP; inst_ex = NOP; inst_mem = NOP; inst_wb = NOP;
    branch_taken = 1'b0; dmem_ready = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input int s, input int f, input logic e);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(s));
    chk({tag, "_flush_cnt"}, 32'(flush_cnt), 32'(f));
    chk({tag, "_mem_err"}, {31'd0, mem_err}, {31'd0, e});
  endtask

  vec_t v_nop, v_lu, v_blu;

  initial begin
    rst = 1'b1;
    inst_id = NOP; inst_ex = NOP; inst_mem = NOP; inst_wb = NOP;
    branch_taken = 1'b0; dmem_ready = 1'b1;

    v_nop = mk(NOP, NOP, NOP, NOP, 0, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
    v_lu  = mk(r_add(6, 5, 2), lw(5, 1), NOP, NOP, 0, 1, 5'b00111, 2'b01, 2'b00, 2'b00, 0);
    v_blu = mk(r_add(6, 5, 2), lw(5, 1), NOP, NOP, 1, 1, 5'b11111, 2'b11, 2'b00, 2'b00, 0);

    tbl[0]  = v_nop;
    tbl[1]  = v_lu;
    tbl[2]  = mk(NOP, r_add(3, 5, 5), addi(5, 0), addi(5, 0), 0, 1, 5'b11111, 2'b00, 2'b10, 2'b10, 0);
    tbl[3]  = mk(NOP, r_add(3, 5, 5), addi(0, 5), addi(5, 0), 0, 1, 5'b11111, 2'b00, 2'b01, 2'b01, 0);
    tbl[4]  = mk(NOP, r_add(3, 5, 7), addi(5, 0), addi(7, 0), 0, 1, 5'b11111, 2'b00, 2'b10, 2'b01, 0);
    tbl[5]  = mk(NOP, i_op(7'b0010011, 3, 5, 12'd5), addi(5, 0), addi(5, 0), 0, 1, 5'b11111, 2'b00, 2'b10, 2'b00, 0);
    tbl[6]  = mk(NOP, 32'h000281B7, addi(5, 0), addi(5, 0), 0, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
    tbl[7]  = v_blu;
    tbl[8]  = mk(r_add(6, 0, 2), lw(0, 1), NOP, NOP, 0, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
    tbl[9]  = mk(s_sw(1, 5), lw(5, 1), NOP, NOP, 0, 1, 5'b00111, 2'b01, 2'b00, 2'b00, 0);
    tbl[10] = mk(32'h000280EF, lw(5, 1), NOP, NOP, 0, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 0);
    tbl[11] = mk(NOP, NOP, s_sw(1, 2), NOP, 0, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 1);
    tbl[12] = mk(NOP, NOP, lw(4, 1), NOP, 0, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 1);
    tbl[13] = mk(NOP, b_beq(1, 2), 32'h00000137, 32'h000000EF, 0, 1, 5'b11111, 2'b00, 2'b01, 2'b10, 0);
    tbl[14] = mk(NOP, i_op(7'b1100111, 1, 3, 12'd3), addi(3, 0), NOP, 0, 1, 5'b11111, 2'b00, 2'b10, 2'b00, 0);

    // reset: outputs forced even with every hazard present
    repeat (2) @(negedge clk);
    step(mk(r_add(6, 5, 2), lw(5, 1), lw(1, 0), NOP, 1, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 0), "rst_forced");
    chk_cnt("rst", 0, 0, 1'b0);
    do_reset();

    for (int i = 0; i < 15; i++) step(tbl[i], $sformatf("vec%0d", i));

    // load-use counts exactly one stall
    do_reset();
    step(v_lu, "lu_c1");
    chk_cnt("lu_c1", 0, 0, 1'b0);
    step(v_nop, "lu_c2");
    chk_cnt("lu_c2", 1, 0, 1'b0);

    // branch overrides load-use
    do_reset();
    step(v_blu, "blu_c1");
    step(v_nop, "blu_c2");
    chk_cnt("blu_c2", 0, 1, 1'b0);

    // three-cycle memory wait with a suppressed branch
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(mk(NOP, NOP, s_sw(1, 2), NOP, 1, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1), $sformatf("mw_c%0d", i));
      chk_cnt($sformatf("mw_c%0d", i), i, 0, 1'b0);
    end
    step(mk(NOP, NOP, s_sw(1, 2), NOP, 0, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 1), "mw_rel");
    step(v_nop, "mw_after");
    chk_cnt("mw_after", 3, 0, 1'b0);
    step(mk(NOP, NOP, lw(4, 1), NOP, 0, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 1), "mw_hit");

    // reset in the middle of MEM_WAIT
    do_reset();
    step(mk(NOP, NOP, lw(4, 1), NOP, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1), "mr_c1");
    step(mk(NOP, NOP, lw(4, 1), NOP, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1), "mr_c2");
    drive(mk(NOP, NOP, lw(4, 1), NOP, 0, 0, 5'b11111, 2'b00, 2'b00, 2'b00, 0));
    rst = 1'b1;
    sample("mr_rst");
    drive(mk(NOP, NOP, lw(4, 1), NOP, 0, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 1));
    rst = 1'b0;
    sample("mr_post");
    chk_cnt("mr_post", 0, 0, 1'b0);

    // watchdog: RUN miss + MEM_TIMEOUT wait cycles, then ERROR until reset
    do_reset();
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
      step(mk(NOP, NOP, lw(1, 0), NOP, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 1), $sformatf("wd_c%0d", i));
      chk($sformatf("wd_c%0d_mem_err", i), {31'd0, mem_err}, 32'd0);
    end
    step(mk(NOP, NOP, lw(1, 0), NOP, 0, 0, 5'b00000, 2'b00, 2'b00, 2'b00, 0), "wd_err");
    chk_cnt("wd_err", 3, 0, 1'b1);
    step(mk(NOP, NOP, lw(1, 0), NOP, 1, 1, 5'b00000, 2'b00, 2'b00, 2'b00, 0), "wd_hold");
    chk_cnt("wd_hold", 3, 0, 1'b1);
    drive(mk(NOP, NOP, lw(1, 0), NOP, 0, 1, 5'b11111, 2'b00, 2'b00, 2'b00, 0));
    rst = 1'b1;
    sample("wd_rst");
    drive(v_nop);
    rst = 1'b0;
    sample("wd_post");
    chk_cnt("wd_post", 0, 0, 1'b0);

    // saturation of a 2-bit stall counter
    do_reset();
    for (int i = 0; i < 5; i++) step(v_lu, $sformatf("sat_c%0d", i));
    step(v_nop, "sat_end");
    chk_cnt("sat_end", 3, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
